// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and constants for the instruction fetch front end.
//   - fetch_state_t : fetch FSM state encoding (ST_FAULT exists only when
//                     IFETCH_ALIGN_CHK_EN is defined)
//   - fetch_entry_t : prefetch buffer payload {inst, pc}
//   - PC_INC        : sequential fetch increment
//   - MCU_RESET_PC  : default fetch address after reset
package mcu_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned FETCH_ENTRY_W = 2 * XLEN;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] MCU_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    ST_FAULT = 2'd2
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch buffer with flush.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push, wdata      : write request and data (ignored when full unless popping)
//   pop              : remove head (ignored when empty)
//   flush            : discard all entries; overrides push and pop
//   rdata            : head entry (stale when empty)
//   full, empty      : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign rdata = r_mem[r_rd_ptr];

  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign w_pop  = pop & ~empty & ~flush;
  assign w_push = push & ~flush & (~full | (pop & ~empty));

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch controller with prefetch buffer.
// Parameters:
//   RESET_PC : fetch address loaded on reset
//   DEPTH    : prefetch buffer entries (power of 2, 2..8)
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   imem_addr, imem_rd  : instruction memory address out / combinational data in
//   inst_valid, inst_ready, inst, inst_pc : decode handshake and head entry
//   redirect_valid, redirect_pc           : branch/jump redirect request
//   halt                : level request to stop fetching
//   fault               : misaligned redirect seen (IFETCH_ALIGN_CHK_EN only)
// Build option: IFETCH_ALIGN_CHK_EN enables the alignment check and FAULT state;
// without it, redirect_pc[1:0] is ignored (treated as zero).
module inst_fetch_ctrl
  import mcu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MCU_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IFETCH_ALIGN_CHK_EN
  output logic        fault,
`endif
  input  logic        halt
);

  fetch_state_t                   r_state;
  logic [31:0]                    r_pc;
  fetch_entry_t                   w_wr_entry;
  fetch_entry_t                   w_rd_entry;
  logic [FETCH_ENTRY_W-1:0]       w_wr_data;
  logic [FETCH_ENTRY_W-1:0]       w_rd_data;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_pop;
  logic                           w_push;
  logic                           w_redirect;
  logic [31:0]                    w_redirect_pc;

`ifdef IFETCH_ALIGN_CHK_EN
  logic r_fault;
  logic w_misaligned;

  // FAULT ignores redirects entirely.
  assign w_misaligned = |redirect_pc[1:0];
  assign w_redirect   = redirect_valid && (r_state != ST_FAULT);
  assign fault        = r_fault;
`else
  logic [1:0] w_unused_lo;

  assign w_unused_lo = redirect_pc[1:0];
  assign w_redirect  = redirect_valid;
`endif

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign imem_addr     = r_pc;
  assign inst_valid    = ~w_empty;

  // The buffer is always empty in FAULT, so the pop needs no state qualifier.
  assign w_pop  = ~w_empty && inst_ready;
  assign w_push = (r_state == ST_RUN) && ~w_redirect && (~w_full || w_pop);

  assign w_wr_entry = '{inst: imem_rd, pc: r_pc};
  assign w_wr_data  = w_wr_entry;
  assign w_rd_entry = fetch_entry_t'(w_rd_data);
  assign inst       = w_rd_entry.inst;
  assign inst_pc    = w_rd_entry.pc;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_wr_data),
    .pop   (w_pop),
    .flush (w_redirect),
    .rdata (w_rd_data),
    .full  (w_full),
    .empty (w_empty)
  );

  // Fetch FSM and PC. State simply follows the halt level; a redirect
  // replaces the sequential PC update and suppresses the push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
`ifdef IFETCH_ALIGN_CHK_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_RUN, ST_HALT: begin
`ifdef IFETCH_ALIGN_CHK_EN
          if (w_redirect && w_misaligned) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else
`endif
          begin
            r_state <= halt ? ST_HALT : ST_RUN;
            if (w_redirect) begin
              r_pc <= w_redirect_pc;
            end else if (w_push) begin
              r_pc <= r_pc + PC_INC;
            end
          end
        end
`ifdef IFETCH_ALIGN_CHK_EN
        ST_FAULT: r_state <= ST_FAULT;
`endif
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule
